// File: rtl/mem_arb_pkg.sv
// Shared types for the block memory arbiter.
// Holds FSM states, owner ids and the block alignment mask.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic {
    ICACHE,
    DCACHE
  } owner_t;

  localparam logic [31:0] BLOCK_ALIGN_MASK = 32'hFFFF_FFF0;

endpackage

// File: rtl/block_mem_arbiter_if.sv
// Bundle between both cache controllers, data memory and the arbiter.
// master: requesters + memory side; slave: the arbiter.
interface block_mem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_WIDTH   = 128
);

  logic                     ic_req;
  logic [ADDRESS_WIDTH-1:0] ic_addr;
  logic                     ic_ready;
  logic [BLOCK_WIDTH-1:0]   ic_rdata;

  logic                     dc_req;
  logic                     dc_we;
  logic [ADDRESS_WIDTH-1:0] dc_addr;
  logic [BLOCK_WIDTH-1:0]   dc_wdata;
  logic                     dc_ready;
  logic [BLOCK_WIDTH-1:0]   dc_rdata;

  logic                     mem_wr_en;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [BLOCK_WIDTH-1:0]   mem_wdata;
  logic [ADDRESS_WIDTH-1:0] mem_read_addr;
  logic [BLOCK_WIDTH-1:0]   mem_rdata;

  modport master (
    output ic_req, ic_addr,
    output dc_req, dc_we, dc_addr, dc_wdata,
    output mem_rdata,
    input  ic_ready, ic_rdata,
    input  dc_ready, dc_rdata,
    input  mem_wr_en, mem_addr, mem_wdata,
    input  mem_read_addr
  );

  modport slave (
    input  ic_req, ic_addr,
    input  dc_req, dc_we, dc_addr, dc_wdata,
    input  mem_rdata,
    output ic_ready, ic_rdata,
    output dc_ready, dc_rdata,
    output mem_wr_en, mem_addr, mem_wdata,
    output mem_read_addr
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant with last_grant register.
// Ports: clk, rst, req[1:0] (0=I$,1=D$), update, one-hot grant.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  owner_t last_grant;

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // tie goes to whoever did not win last
      2'b11:   grant = (last_grant == DCACHE) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant <= DCACHE;
    else if (update && |grant)
      last_grant <= grant[1] ? DCACHE : ICACHE;
  end

endmodule

// File: rtl/block_mem_arbiter.sv
// Shares the 128-bit block memory between I-cache and D-cache.
// Ports: clk, rst, bus (slave side of block_mem_arbiter_if).
module block_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_WIDTH   = 128,
  parameter int MEM_LATENCY   = 4
) (
  input logic                clk,
  input logic                rst,
  block_mem_arbiter_if.slave bus
);

  localparam logic [ADDRESS_WIDTH-1:0] ALIGN =
    ~ADDRESS_WIDTH'(~BLOCK_ALIGN_MASK);
  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t                   state, next;
  owner_t                   own;
  logic [3:0]               cnt;
  logic [ADDRESS_WIDTH-1:0] lat_addr;
  logic                     lat_we;
  logic [BLOCK_WIDTH-1:0]   lat_data;
  logic [BLOCK_WIDTH-1:0]   ic_q, dc_q;
  logic [1:0]               req, grant;
  logic                     take, in_wait;

  assign req     = {bus.dc_req, bus.ic_req};
  assign take    = (state == IDLE) && |req;
  assign in_wait = (state == WAIT);

  rr_arb2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (take),
    .grant  (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (|req) next = WAIT;
      WAIT:    if (cnt == 4'd0) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own      <= ICACHE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_we   <= 1'b0;
      lat_data <= '0;
      ic_q     <= '0;
      dc_q     <= '0;
    end else begin
      if (take) begin
        own      <= grant[1] ? DCACHE : ICACHE;
        lat_addr <= (grant[1] ? bus.dc_addr : bus.ic_addr) & ALIGN;
        lat_we   <= grant[1] & bus.dc_we;
        lat_data <= grant[1] ? bus.dc_wdata : '0;
        cnt      <= LAT_M1;
      end
      if (in_wait) begin
        if (cnt != 4'd0)
          cnt <= cnt - 4'd1;
        else if (!lat_we) begin
          // read block captured on the edge leaving WAIT
          if (own == ICACHE) ic_q <= bus.mem_rdata;
          else               dc_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.ic_ready      = (state == DONE) && (own == ICACHE);
  assign bus.dc_ready      = (state == DONE) && (own == DCACHE);
  assign bus.ic_rdata      = ic_q;
  assign bus.dc_rdata      = dc_q;
  assign bus.mem_addr      = in_wait ? lat_addr : '0;
  assign bus.mem_read_addr = in_wait ? lat_addr : '0;
  assign bus.mem_wdata     = in_wait ? lat_data : '0;
  assign bus.mem_wr_en     = in_wait && (cnt == 4'd0) && lat_we;

endmodule

// File: tb/tb_block_mem_arbiter.sv
// Scoreboard bench for block_mem_arbiter (latency 4 and latency 1).
// Drivers push expected responses; negedge monitors pop and compare.
module tb_block_mem_arbiter;

  typedef struct {
    bit           dc;
    logic [127:0] data;
    bit           chk;
    int           cyc;
  } rsp_t;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    int           cyc;
  } wr_t;

  localparam logic [127:0] D0 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] DA = {16{8'hAA}};
  localparam logic [127:0] D5 = {16{8'h55}};
  localparam logic [127:0] DB = 128'h123456789ABCDEF0_0FEDCBA987654321;
  localparam logic [127:0] DC = {16{8'hC3}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  rsp_t rq4[$], rq1[$];
  wr_t  wq4[$];
  rsp_t e4, e1;
  wr_t  w4;

  logic [127:0] mem4 [16];
  logic [127:0] mem1 [16];

  block_mem_arbiter_if b4 ();
  block_mem_arbiter_if b1 ();

  block_mem_arbiter #(.MEM_LATENCY(4)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (b4.slave)
  );

  block_mem_arbiter #(.MEM_LATENCY(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  always #5 clk = ~clk;

  assign b4.mem_rdata = mem4[b4.mem_read_addr[7:4]];
  assign b1.mem_rdata = mem1[b1.mem_read_addr[7:4]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (b4.mem_wr_en) mem4[b4.mem_addr[7:4]] <= b4.mem_wdata;
    if (b1.mem_wr_en) mem1[b1.mem_addr[7:4]] <= b1.mem_wdata;
  end

  task automatic chk(string n, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask

  // latency-4 monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (b4.ic_ready || b4.dc_ready) begin
        if (rq4.size() == 0)
          chk("l4_unexpected_ready",
              128'({b4.dc_ready, b4.ic_ready}), 128'(0));
        else begin
          e4 = rq4.pop_front();
          chk("l4_ready_owner", 128'(b4.dc_ready), 128'(e4.dc));
          chk("l4_ready_other",
              128'(e4.dc ? b4.ic_ready : b4.dc_ready), 128'(0));
          chk("l4_ready_cycle", 128'(cyc), 128'(e4.cyc));
          if (e4.chk)
            chk("l4_rdata", e4.dc ? b4.dc_rdata : b4.ic_rdata, e4.data);
        end
      end
      if (b4.mem_wr_en) begin
        if (wq4.size() == 0)
          chk("l4_unexpected_write", 128'(b4.mem_addr), 128'(0));
        else begin
          w4 = wq4.pop_front();
          chk("l4_wr_addr", 128'(b4.mem_addr), 128'(w4.addr));
          chk("l4_wr_data", b4.mem_wdata, w4.data);
          chk("l4_wr_cycle", 128'(cyc), 128'(w4.cyc));
        end
      end
    end
  end

  // latency-1 monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (b1.mem_wr_en)
        chk("l1_unexpected_write", 128'(b1.mem_addr), 128'(0));
      if (b1.ic_ready || b1.dc_ready) begin
        if (rq1.size() == 0)
          chk("l1_unexpected_ready",
              128'({b1.dc_ready, b1.ic_ready}), 128'(0));
        else begin
          e1 = rq1.pop_front();
          chk("l1_ready_owner", 128'(b1.dc_ready), 128'(e1.dc));
          chk("l1_ready_cycle", 128'(cyc), 128'(e1.cyc));
          if (e1.chk)
            chk("l1_rdata", b1.dc_rdata, e1.data);
        end
      end
    end
  end

  task automatic reset_chk(string n);
    chk({n, "_ic_ready"}, 128'(b4.ic_ready), 128'(0));
    chk({n, "_dc_ready"}, 128'(b4.dc_ready), 128'(0));
    chk({n, "_wr_en"}, 128'(b4.mem_wr_en), 128'(0));
    chk({n, "_rd_addr"}, 128'(b4.mem_read_addr), 128'(0));
  endtask

  // one transaction on the latency-4 arbiter
  task automatic do_req(bit dc, bit we, logic [31:0] a,
                        logic [127:0] wd, logic [127:0] rd);
    int  e0;
    bit  got;
    logic [31:0] al;
    al = a & 32'hFFFF_FFF0;
    @(posedge clk); #1;
    e0 = cyc + 1;
    if (dc) begin
      b4.dc_req = 1'b1; b4.dc_we = we;
      b4.dc_addr = a; b4.dc_wdata = wd;
    end else begin
      b4.ic_req = 1'b1; b4.ic_addr = a;
    end
    rq4.push_back('{dc: dc, data: rd, chk: !we, cyc: e0 + 4});
    if (we) wq4.push_back('{addr: al, data: wd, cyc: e0 + 3});
    @(negedge clk);
    @(negedge clk);
    chk("wait_rd_addr", 128'(b4.mem_read_addr), 128'(al));
    chk("wait_addr", 128'(b4.mem_addr), 128'(al));
    // scramble request fields; latched copies must be used
    b4.dc_addr = 32'h0000_00F0; b4.dc_wdata = '0;
    b4.ic_addr = 32'h0000_00F0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b4.ic_ready || b4.dc_ready) begin got = 1'b1; break; end
    end
    if (!got) chk("ready_timeout", 128'(0), 128'(1));
    else chk("done_rd_addr", 128'(b4.mem_read_addr), 128'(0));
    b4.ic_req = 1'b0; b4.dc_req = 1'b0; b4.dc_we = 1'b0;
  endtask

  initial begin : stim
    int e0;
    int n;
    for (int i = 0; i < 16; i++) begin
      mem4[i] = '0;
      mem1[i] = '0;
    end
    mem4[0] = D0;
    mem1[3] = DC;
    b4.ic_req = 0; b4.ic_addr = '0; b4.dc_req = 0; b4.dc_we = 0;
    b4.dc_addr = '0; b4.dc_wdata = '0;
    b1.ic_req = 0; b1.ic_addr = '0; b1.dc_req = 0; b1.dc_we = 0;
    b1.dc_addr = '0; b1.dc_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_chk("rst0");
    chk("rst0_ic_rdata", b4.ic_rdata, '0);
    rst = 1'b0;

    do_req(1'b0, 1'b0, 32'h0001_0004, '0, D0);
    do_req(1'b1, 1'b1, 32'h0001_002C, DA, '0);
    do_req(1'b1, 1'b0, 32'h0001_0020, '0, DA);
    do_req(1'b1, 1'b1, 32'h0001_0048, D5, '0);
    do_req(1'b1, 1'b0, 32'h0001_0040, '0, D5);
    do_req(1'b1, 1'b1, 32'hFFFF_FFF8, DB, '0);
    do_req(1'b0, 1'b0, 32'hFFFF_FFF4, '0, DB);

    // fresh reset, then held tie: I, D, I
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    reset_chk("rst1");
    rst = 1'b0;
    @(posedge clk); #1;
    e0 = cyc + 1;
    b4.ic_req = 1'b1; b4.ic_addr = 32'h0001_0000;
    b4.dc_req = 1'b1; b4.dc_we = 1'b0; b4.dc_addr = 32'h0001_0020;
    rq4.push_back('{dc: 1'b0, data: D0, chk: 1'b1, cyc: e0 + 4});
    rq4.push_back('{dc: 1'b1, data: DA, chk: 1'b1, cyc: e0 + 10});
    rq4.push_back('{dc: 1'b0, data: D0, chk: 1'b1, cyc: e0 + 16});
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (b4.ic_ready || b4.dc_ready) n++;
      if (n == 3) break;
    end
    chk("tie_count", 128'(n), 128'(3));
    b4.ic_req = 1'b0; b4.dc_req = 1'b0;

    // reset in the second WAIT cycle of a write-back
    @(posedge clk); #1;
    b4.dc_req = 1'b1; b4.dc_we = 1'b1;
    b4.dc_addr = 32'h0001_0064; b4.dc_wdata = {16{8'h77}};
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    b4.dc_req = 1'b0; b4.dc_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_chk("rst2");
    rst = 1'b0;
    chk("abort_mem", mem4[6], '0);
    do_req(1'b0, 1'b0, 32'h0001_0008, '0, D0);
    chk("abort_mem_after", mem4[6], '0);

    // latency 1: held D-cache read, grants 3 cycles apart
    @(posedge clk); #1;
    e0 = cyc + 1;
    b1.dc_req = 1'b1; b1.dc_addr = 32'h0001_0030;
    rq1.push_back('{dc: 1'b1, data: DC, chk: 1'b1, cyc: e0 + 1});
    rq1.push_back('{dc: 1'b1, data: DC, chk: 1'b1, cyc: e0 + 4});
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (b1.dc_ready) n++;
      if (n == 2) break;
    end
    chk("l1_count", 128'(n), 128'(2));
    b1.dc_req = 1'b0;

    repeat (8) @(posedge clk);
    #1;
    chk("rq4_drained", 128'(rq4.size()), 128'(0));
    chk("wq4_drained", 128'(wq4.size()), 128'(0));
    chk("rq1_drained", 128'(rq1.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule
